// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: shares the single tone/amplifier path between an alarm
// level, an error burst and a keypress chirp, and times each cadence in ms.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | silent, waiting for a pending error or keypress
// CHIRP      | keypress chirp at the high tone for CHIRP_MS
// ERR_ON     | error burst on-phase at the low tone for ERR_ON_MS
// ERR_OFF    | error burst gap for ERR_OFF_MS (skipped after the last on-phase)
// ALARM_ON   | alarm on-phase at the low tone for ALARM_ON_MS
// ALARM_OFF  | alarm gap for ALARM_OFF_MS
module buzzer_scheduler #(
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned CHIRP_MS     = 50,
   parameter int unsigned ERR_ON_MS    = 100,
   parameter int unsigned ERR_OFF_MS   = 100,
   parameter int unsigned ERR_COUNT    = 3,
   parameter int unsigned ALARM_ON_MS  = 500,
   parameter int unsigned ALARM_OFF_MS = 500,
   parameter int unsigned HALF_LO      = 113636,
   parameter int unsigned HALF_HI      = 56818
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alarm_req,
   input  logic        err_pulse,
   input  logic        key_pulse,
   input  logic        mute,
   output logic        tone_en,
   output logic [16:0] tone_half,
   output logic        amp_en,
   output logic        busy,
   output logic [1:0]  src
);

   localparam int unsigned MS_MAX_A = (CHIRP_MS > ERR_ON_MS) ? CHIRP_MS : ERR_ON_MS;
   localparam int unsigned MS_MAX_B = (ERR_OFF_MS > ALARM_ON_MS) ? ERR_OFF_MS : ALARM_ON_MS;
   localparam int unsigned MS_MAX_C = (MS_MAX_A > MS_MAX_B) ? MS_MAX_A : MS_MAX_B;
   localparam int unsigned MS_MAX   = (MS_MAX_C > ALARM_OFF_MS) ? MS_MAX_C : ALARM_OFF_MS;

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MS_W    = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
   localparam int BURST_W = $clog2(ERR_COUNT + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST     = PRESC_W'(TICK_DIV - 1);
   localparam logic [MS_W-1:0]    CHIRP_LAST     = MS_W'(CHIRP_MS - 1);
   localparam logic [MS_W-1:0]    ERR_ON_LAST    = MS_W'(ERR_ON_MS - 1);
   localparam logic [MS_W-1:0]    ERR_OFF_LAST   = MS_W'(ERR_OFF_MS - 1);
   localparam logic [MS_W-1:0]    ALARM_ON_LAST  = MS_W'(ALARM_ON_MS - 1);
   localparam logic [MS_W-1:0]    ALARM_OFF_LAST = MS_W'(ALARM_OFF_MS - 1);
   localparam logic [BURST_W-1:0] BURST_N        = BURST_W'(ERR_COUNT);
   localparam logic [16:0]        HALF_LO_V      = 17'(HALF_LO);
   localparam logic [16:0]        HALF_HI_V      = 17'(HALF_HI);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHIRP,
      S_ERR_ON,
      S_ERR_OFF,
      S_ALARM_ON,
      S_ALARM_OFF
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [PRESC_W-1:0]   presc;
   logic [MS_W-1:0]      ms_cnt;
   logic [MS_W-1:0]      ms_last;
   logic [BURST_W-1:0]   burst_cnt;
   logic [BURST_W-1:0]   burst_inc;
   logic                 pend_key;
   logic                 pend_err;
   logic                 pend_key_nxt;
   logic                 pend_err_nxt;
   logic                 key_seen;
   logic                 err_seen;
   logic                 in_alarm;
   logic                 in_err;
   logic                 alarm_entry;
   logic                 entering;
   logic                 phase_done;

   // Next-state arbitration: mute, then alarm, then pending error, then chirp.
   // Pulses arriving this cycle count as pending so service starts next cycle.
   always_comb begin
      in_alarm  = (state == S_ALARM_ON) || (state == S_ALARM_OFF);
      in_err    = (state == S_ERR_ON) || (state == S_ERR_OFF);
      key_seen  = pend_key | (key_pulse & (state != S_CHIRP));
      err_seen  = pend_err | (err_pulse & ~in_err);
      burst_inc = burst_cnt + 1'b1;

      ms_last = '0;
      case (state)
         S_CHIRP:     ms_last = CHIRP_LAST;
         S_ERR_ON:    ms_last = ERR_ON_LAST;
         S_ERR_OFF:   ms_last = ERR_OFF_LAST;
         S_ALARM_ON:  ms_last = ALARM_ON_LAST;
         S_ALARM_OFF: ms_last = ALARM_OFF_LAST;
         default:     ms_last = '0;
      endcase
      phase_done = (presc == PRESC_LAST) && (ms_cnt == ms_last);

      state_nxt = state;
      if (mute) begin
         state_nxt = S_IDLE;
      end else if (alarm_req && !in_alarm) begin
         state_nxt = S_ALARM_ON;
      end else begin
         case (state)
            S_IDLE: begin
               if (err_seen)      state_nxt = S_ERR_ON;
               else if (key_seen) state_nxt = S_CHIRP;
            end
            S_CHIRP: begin
               if (phase_done) state_nxt = S_IDLE;
            end
            S_ERR_ON: begin
               if (phase_done) state_nxt = (burst_inc == BURST_N) ? S_IDLE : S_ERR_OFF;
            end
            S_ERR_OFF: begin
               if (phase_done) state_nxt = S_ERR_ON;
            end
            S_ALARM_ON: begin
               if (!alarm_req)      state_nxt = S_IDLE;
               else if (phase_done) state_nxt = S_ALARM_OFF;
            end
            S_ALARM_OFF: begin
               if (!alarm_req)      state_nxt = S_IDLE;
               else if (phase_done) state_nxt = S_ALARM_ON;
            end
            default: state_nxt = S_IDLE;
         endcase
      end

      entering    = (state_nxt != state);
      alarm_entry = (state_nxt == S_ALARM_ON) && !in_alarm;

      pend_key_nxt = key_seen;
      pend_err_nxt = err_seen;
      if (mute || alarm_entry) begin
         pend_key_nxt = 1'b0;
         pend_err_nxt = 1'b0;
      end else begin
         if (entering && (state_nxt == S_CHIRP))  pend_key_nxt = 1'b0;
         if (entering && (state_nxt == S_ERR_ON)) pend_err_nxt = 1'b0;
      end
   end

   // State, phase timers, pending latches and outputs decoded from next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         presc     <= '0;
         ms_cnt    <= '0;
         burst_cnt <= '0;
         pend_key  <= 1'b0;
         pend_err  <= 1'b0;
         tone_en   <= 1'b0;
         amp_en    <= 1'b0;
         tone_half <= '0;
         busy      <= 1'b0;
         src       <= 2'd0;
      end else begin
         state    <= state_nxt;
         pend_key <= pend_key_nxt;
         pend_err <= pend_err_nxt;

         if (entering || (state == S_IDLE)) begin
            presc  <= '0;
            ms_cnt <= '0;
         end else if (presc == PRESC_LAST) begin
            presc  <= '0;
            ms_cnt <= ms_cnt + 1'b1;
         end else begin
            presc  <= presc + 1'b1;
         end

         // Burst count lives only across ERR_ON/ERR_OFF; any exit discards it.
         if ((state_nxt != S_ERR_ON) && (state_nxt != S_ERR_OFF))
            burst_cnt <= '0;
         else if ((state == S_ERR_ON) && phase_done)
            burst_cnt <= burst_inc;

         case (state_nxt)
            S_CHIRP: begin
               tone_en   <= 1'b1;
               amp_en    <= 1'b1;
               tone_half <= HALF_HI_V;
               busy      <= 1'b1;
               src       <= 2'd1;
            end
            S_ERR_ON: begin
               tone_en   <= 1'b1;
               amp_en    <= 1'b1;
               tone_half <= HALF_LO_V;
               busy      <= 1'b1;
               src       <= 2'd2;
            end
            S_ERR_OFF: begin
               tone_en   <= 1'b0;
               amp_en    <= 1'b0;
               busy      <= 1'b1;
               src       <= 2'd2;
            end
            S_ALARM_ON: begin
               tone_en   <= 1'b1;
               amp_en    <= 1'b1;
               tone_half <= HALF_LO_V;
               busy      <= 1'b1;
               src       <= 2'd3;
            end
            S_ALARM_OFF: begin
               tone_en   <= 1'b0;
               amp_en    <= 1'b0;
               busy      <= 1'b1;
               src       <= 2'd3;
            end
            default: begin
               tone_en   <= 1'b0;
               amp_en    <= 1'b0;
               busy      <= 1'b0;
               src       <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler with a 10-cycle ms tick.
module tb_buzzer_scheduler;

   localparam int HI = 56818;
   localparam int LO = 113636;

   logic        clk;
   logic        rst_n;
   logic        alarm_req;
   logic        err_pulse;
   logic        key_pulse;
   logic        mute;
   logic        tone_en;
   logic [16:0] tone_half;
   logic        amp_en;
   logic        busy;
   logic [1:0]  src;

   int n_cmp = 0;
   int n_err = 0;

   buzzer_scheduler #(.TICK_DIV(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alarm_req (alarm_req),
      .err_pulse (err_pulse),
      .key_pulse (key_pulse),
      .mute      (mute),
      .tone_en   (tone_en),
      .tone_half (tone_half),
      .amp_en    (amp_en),
      .busy      (busy),
      .src       (src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_out(input string tag, input int en, input int half,
                          input int s, input int b);
      chk({tag, "_tone_en"},   int'(tone_en),   en);
      chk({tag, "_amp_en"},    int'(amp_en),    en);
      chk({tag, "_tone_half"}, int'(tone_half), half);
      chk({tag, "_src"},       int'(src),       s);
      chk({tag, "_busy"},      int'(busy),      b);
   endtask

   task automatic pulse_key();
      key_pulse = 1'b1;
      step(1);
      key_pulse = 1'b0;
   endtask

   task automatic pulse_err();
      err_pulse = 1'b1;
      step(1);
      err_pulse = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      alarm_req = 1'b0;
      err_pulse = 1'b0;
      key_pulse = 1'b0;
      mute      = 1'b0;
      step(3);
      chk_out("rst_init", 0, 0, 0, 0);
      rst_n = 1'b1;
      step(2);

      // 1: async reset in the middle of an alarm on-phase
      alarm_req = 1'b1;
      step(1);
      chk_out("t1_alarm", 1, LO, 3, 1);
      step(50);
      rst_n = 1'b0;
      alarm_req = 1'b0;
      #1;
      chk_out("t1_async", 0, 0, 0, 0);
      step(2);
      rst_n = 1'b1;
      step(20);
      chk_out("t1_idle", 0, 0, 0, 0);

      // 2: chirp lasts exactly 500 cycles at the high tone
      pulse_key();
      chk_out("t2_start", 1, HI, 1, 1);
      step(499);
      chk_out("t2_last", 1, HI, 1, 1);
      step(1);
      chk_out("t2_end", 0, HI, 0, 0);
      step(5);

      // 3: error burst of three 1000-cycle on-phases with 1000-cycle gaps
      pulse_err();
      chk_out("t3_on1", 1, LO, 2, 1);
      step(999);
      chk_out("t3_on1_last", 1, LO, 2, 1);
      step(1);
      chk_out("t3_off1", 0, LO, 2, 1);
      step(999);
      chk_out("t3_off1_last", 0, LO, 2, 1);
      step(1);
      chk_out("t3_on2", 1, LO, 2, 1);
      step(2999);
      chk_out("t3_on3_last", 1, LO, 2, 1);
      step(1);
      chk_out("t3_end", 0, LO, 0, 0);
      step(5);

      // 4: simultaneous error and key: burst, one idle cycle, then chirp
      err_pulse = 1'b1;
      key_pulse = 1'b1;
      step(1);
      err_pulse = 1'b0;
      key_pulse = 1'b0;
      chk_out("t4_err", 1, LO, 2, 1);
      step(4999);
      chk_out("t4_err_last", 1, LO, 2, 1);
      step(1);
      chk_out("t4_gap", 0, LO, 0, 0);
      step(1);
      chk_out("t4_chirp", 1, HI, 1, 1);
      step(499);
      chk_out("t4_chirp_last", 1, HI, 1, 1);
      step(1);
      chk_out("t4_end", 0, HI, 0, 0);
      step(5);

      // 5: alarm pre-empts a chirp, cadences 5000/5000, drops straight to idle
      pulse_key();
      step(199);
      chk_out("t5_chirp", 1, HI, 1, 1);
      alarm_req = 1'b1;
      step(1);
      chk_out("t5_alarm", 1, LO, 3, 1);
      step(4999);
      chk_out("t5_on_last", 1, LO, 3, 1);
      step(1);
      chk_out("t5_off", 0, LO, 3, 1);
      step(4999);
      chk_out("t5_off_last", 0, LO, 3, 1);
      step(1);
      chk_out("t5_on2", 1, LO, 3, 1);
      step(100);
      alarm_req = 1'b0;
      step(1);
      chk_out("t5_drop", 0, LO, 0, 0);
      step(30);
      chk_out("t5_no_replay", 0, LO, 0, 0);

      // 6: mute during the error gap clears the pending keypress
      pulse_err();
      step(1099);
      chk_out("t6_off", 0, LO, 2, 1);
      pulse_key();
      chk_out("t6_key_ign", 0, LO, 2, 1);
      step(50);
      mute = 1'b1;
      step(1);
      chk_out("t6_mute", 0, LO, 0, 0);
      step(5);
      mute = 1'b0;
      step(1);
      chk_out("t6_release", 0, LO, 0, 0);
      step(30);
      chk_out("t6_silent", 0, LO, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/buzzer_scheduler.md
Name: buzzer_scheduler

Overview:
Sequencing and arbitration controller that sits in front of the square-wave tone generator and the PmodAMP2 amplifier. It shares the single audio path between three requesters: a level-sensitive alarm, a pulsed error indication, and a pulsed keypress chirp. It converts each request into a timed on/off cadence, drives the tone generator's enable and half-period, and gates the amplifier. A global mute overrides everything.

Parameters:
TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clock).
CHIRP_MS, 50, keypress chirp length in ms.
ERR_ON_MS, 100, error burst on-phase in ms.
ERR_OFF_MS, 100, error burst off-phase in ms.
ERR_COUNT, 3, number of on-phases per error burst.
ALARM_ON_MS, 500, alarm on-phase in ms.
ALARM_OFF_MS, 500, alarm off-phase in ms.
HALF_LO, 113636, half-period count for 440 Hz (error and alarm tone).
HALF_HI, 56818, half-period count for 880 Hz (chirp tone).

Ports:
clk  in  1  100 MHz system clock
rst_n  in  1  asynchronous active-low reset
alarm_req  in  1  level; alarm requested while high
err_pulse  in  1  single-cycle error event
key_pulse  in  1  single-cycle keypress event
mute  in  1  level; forces silence and clears pending requests
tone_en  out  1  enable to tone generator
tone_half  out  17  half-period count to tone generator
amp_en  out  1  amplifier enable (shutdown released when high); equals tone_en
busy  out  1  high in any state other than IDLE
src  out  2  active source: 0 none, 1 chirp, 2 error, 3 alarm

Behaviour:
- Reset (async, rst_n=0): state IDLE, all counters 0, pend_key=pend_err=0, tone_en=0, amp_en=0, tone_half=0, busy=0, src=0.
- States: IDLE, CHIRP, ERR_ON, ERR_OFF, ALARM_ON, ALARM_OFF. All outputs are registered and decoded from the next state, so they change 1 cycle after the causing input edge.
- Pending latches: key_pulse sets pend_key; err_pulse sets pend_err. Each latch clears when its service state is entered. err_pulse is ignored in ERR_ON/ERR_OFF. key_pulse is ignored in CHIRP.
- Priority, evaluated every cycle:
  - mute: go to IDLE and clear both pendings.
  - Else alarm_req: from any non-alarm state, go to ALARM_ON. Entry clears both pendings, and any chirp or error burst in progress is abandoned.
  - From IDLE, otherwise: pend_err goes to ERR_ON, else pend_key goes to CHIRP.
- Phase timing: a ms counter and prescaler reset on every state entry. A phase of N ms lasts exactly N*TICK_DIV cycles of tone_en at its value.
- CHIRP: tone_en=1, tone_half=HALF_HI. Goes to IDLE after CHIRP_MS.
- ERR_ON: tone_en=1, tone_half=HALF_LO. After ERR_ON_MS, increment burst_cnt.
  - If burst_cnt reaches ERR_COUNT, go to IDLE. The final off-phase is skipped.
  - Otherwise go to ERR_OFF (tone_en=0), then back to ERR_ON after ERR_OFF_MS.
- ALARM_ON / ALARM_OFF: alternate with ALARM_ON_MS / ALARM_OFF_MS at HALF_LO for as long as alarm_req stays high. When alarm_req drops, go to IDLE on the next cycle in either phase; no phase completion.
- tone_half holds its last value while tone_en=0. It is 0 only after reset.
- busy=1 and src≠0 in every non-IDLE state, including off-phases.
- Simultaneous err_pulse and key_pulse in IDLE: error is served first; the chirp follows immediately after the burst returns to IDLE (one IDLE cycle in between).
- Counter widths: prescaler sized to TICK_DIV-1, ms counter sized to the maximum of the *_MS parameters, burst counter sized to ERR_COUNT. No wrap is reachable.

Test Plan (bench parameters TICK_DIV=10, defaults otherwise):
1. rst_n=0 mid-ALARM_ON → tone_en, amp_en, busy, src, tone_half all 0 immediately. After release, remains IDLE with no input activity.
2. key_pulse at cycle t → tone_en=1, tone_half=56818, src=1 from t+1 for exactly 500 cycles. Then tone_en=0, busy=0.
3. err_pulse → tone_en high for 1000 cycles, low for 1000, three on-phases total (5000 cycles busy), tone_half=113636, src=2. Then IDLE.
4. err_pulse and key_pulse in the same cycle → 5000-cycle error burst, one IDLE cycle, then a 500-cycle chirp at 56818.
5. alarm_req raised 200 cycles into a chirp → next cycle src=3, tone_half=113636, chirp abandoned. Alarm runs on 5000 / off 5000 cycles. alarm_req drop → IDLE next cycle, no pending chirp replayed.
6. mute held during ERR_OFF with a key_pulse pending → IDLE next cycle, pendings cleared. After mute releases, no tone occurs.
